// File: rtl/doy_calendar_sequencer_if.sv
// Front-panel calendar bus: day strobe, pause, set-date request/response and current date.
// The master modport drives requests; the slave modport (the sequencer) drives date and status.
interface doy_calendar_sequencer_if;
   logic       i_day_tick;
   logic       i_pause;
   logic       i_load_req;
   logic [7:0] i_load_doy;
   logic [1:0] i_load_year;
   logic [7:0] o_doy;
   logic [1:0] o_year_cnt;
   logic       o_year_leap;
   logic       o_rollover;
   logic       o_load_ack;
   logic       o_load_err;

   modport master (
      output i_day_tick, i_pause, i_load_req, i_load_doy, i_load_year,
      input  o_doy, o_year_cnt, o_year_leap, o_rollover, o_load_ack, o_load_err
   );

   modport slave (
      input  i_day_tick, i_pause, i_load_req, i_load_doy, i_load_year,
      output o_doy, o_year_cnt, o_year_leap, o_rollover, o_load_ack, o_load_err
   );
endinterface

// File: rtl/doy_calendar_sequencer.sv
// Day-of-year / year sequencer feeding the month/day decoder; ticks advance in 1 cycle.
// Set-date is acked 2 cycles after load_req; requests arriving while a check is pending are dropped.
module doy_calendar_sequencer #(
   parameter int         LAST_DOY   = 120,
   parameter logic [1:0] RESET_YEAR = 2'd0
) (
   input logic               i_clk,
   input logic               i_reset,
   doy_calendar_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_CHECK  = 2'd2
   } state_t;

   localparam logic [7:0] LAST = 8'(LAST_DOY);

   state_t     r_state;
   logic [7:0] r_doy;
   logic [1:0] r_year;
   logic [7:0] r_ld_doy;
   logic [1:0] r_ld_year;
   logic       r_rollover;
   logic       r_ack;
   logic       r_err;

   state_t     w_state_nxt;
   logic [7:0] w_doy_nxt;
   logic [1:0] w_year_nxt;
   logic       w_cap;
   logic       w_roll_nxt;
   logic       w_ack_nxt;
   logic       w_err_nxt;
   logic       w_leap;
   logic [7:0] w_lim;
   logic [7:0] w_ld_lim;
   logic       w_ld_ok;

   assign w_leap   = (r_year == 2'd0);
   assign w_lim    = LAST + {7'd0, w_leap};
   // Load limit follows the requested year, not the current one.
   assign w_ld_lim = LAST + {7'd0, (r_ld_year == 2'd0)};
   assign w_ld_ok  = (r_ld_doy != 8'd0) && (r_ld_doy <= w_ld_lim);

   always_comb begin
      w_state_nxt = r_state;
      w_doy_nxt   = r_doy;
      w_year_nxt  = r_year;
      w_cap       = 1'b0;
      w_roll_nxt  = 1'b0;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (bus.i_load_req) begin
               w_cap       = 1'b1;
               w_state_nxt = ST_CHECK;
            end else if (bus.i_pause) begin
               w_state_nxt = ST_PAUSED;
            end else if (bus.i_day_tick) begin
               if (r_doy == w_lim) begin
                  w_doy_nxt  = 8'd1;
                  w_year_nxt = r_year + 2'd1;
                  w_roll_nxt = 1'b1;
               end else begin
                  w_doy_nxt = r_doy + 8'd1;
               end
            end
         end
         ST_PAUSED: begin
            if (bus.i_load_req) begin
               w_cap       = 1'b1;
               w_state_nxt = ST_CHECK;
            end else if (!bus.i_pause) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_CHECK: begin
            w_ack_nxt = 1'b1;
            if (w_ld_ok) begin
               w_doy_nxt  = r_ld_doy;
               w_year_nxt = r_ld_year;
            end else begin
               w_err_nxt = 1'b1;
            end
            w_state_nxt = bus.i_pause ? ST_PAUSED : ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_RUN;
         r_doy      <= 8'd1;
         r_year     <= RESET_YEAR;
         r_ld_doy   <= 8'd0;
         r_ld_year  <= 2'd0;
         r_rollover <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_doy      <= w_doy_nxt;
         r_year     <= w_year_nxt;
         r_rollover <= w_roll_nxt;
         r_ack      <= w_ack_nxt;
         r_err      <= w_err_nxt;
         if (w_cap) begin
            r_ld_doy  <= bus.i_load_doy;
            r_ld_year <= bus.i_load_year;
         end
      end
   end

   assign bus.o_doy       = r_doy;
   assign bus.o_year_cnt  = r_year;
   assign bus.o_year_leap = w_leap;
   assign bus.o_rollover  = r_rollover;
   assign bus.o_load_ack  = r_ack;
   assign bus.o_load_err  = r_err;

endmodule
